// File: rtl/elc3_display_pkg.sv
// Shared definitions for the eLC-3 display console: FSM states, sub-operations
// and the character codes the console decodes.
package elc3_display_pkg;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    WRITE,
    CLEAR_LINE
  } state_e;

  // What the single-cycle WRITE state does with the cursor cell.
  typedef enum logic [1:0] {
    OpPut,
    OpErase,
    OpNop
  } write_op_e;

  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  function automatic logic is_printable(logic [7:0] c);
    return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/display_console_controller.sv
// Consumes characters written to DDR and renders them into a COLS x ROWS text
// buffer, handling cursor advance, control codes, wrap and clearing.
module display_console_controller
  import elc3_display_pkg::*;
#(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              DDR_Write,
  input  logic [15:0]       Data_FromDDR,
  output logic              DSR_Ready,
  output logic              VRAM_WE,
  output logic [ADDR_W-1:0] VRAM_ADDR,
  output logic [7:0]        VRAM_DATA,
  output logic [6:0]        Cursor_Col,
  output logic [4:0]        Cursor_Row
);

  localparam int unsigned       Cells     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LastCell  = ADDR_W'(Cells - 1);
  localparam logic [ADDR_W-1:0] LastLineI = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ColsA     = ADDR_W'(COLS);
  localparam logic [6:0]        LastCol   = 7'(COLS - 1);
  localparam logic [4:0]        LastRow   = 5'(ROWS - 1);

  state_e            state_q, state_d;
  write_op_e         op_q, op_d;
  logic [7:0]        ch_q, ch_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic [7:0]        c;
  logic [4:0]        row_next;
  logic [ADDR_W-1:0] row_base;
  logic              unused_hi;

  assign c         = Data_FromDDR[7:0];
  assign unused_hi = ^Data_FromDDR[15:8];
  // Rows wrap to the top; there is no scrolling.
  assign row_next  = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
  assign row_base  = ADDR_W'(row_q) * ColsA;

  assign Cursor_Col = col_q;
  assign Cursor_Row = row_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ch_d      = ch_q;
    col_d     = col_q;
    row_d     = row_q;
    idx_d     = idx_q;
    DSR_Ready = 1'b0;
    VRAM_WE   = 1'b0;
    VRAM_ADDR = row_base + ADDR_W'(col_q);
    VRAM_DATA = ch_q;

    case (state_q)
      CLEAR_ALL: begin
        VRAM_WE   = 1'b1;
        VRAM_ADDR = idx_q;
        VRAM_DATA = CH_SPACE;
        if (idx_q == LastCell) begin
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      IDLE: begin
        DSR_Ready = 1'b1;
        if (DDR_Write) begin
          if (is_printable(c)) begin
            ch_d    = c;
            op_d    = OpPut;
            state_d = WRITE;
          end else begin
            case (c)
              CH_LF: begin
                col_d   = '0;
                row_d   = row_next;
                idx_d   = '0;
                state_d = CLEAR_LINE;
              end
              CH_CR: begin
                col_d   = '0;
                op_d    = OpNop;
                state_d = WRITE;
              end
              CH_BS: begin
                // Step back first so WRITE blanks the cell we moved onto.
                if (col_q != 7'd0) begin
                  col_d = col_q - 7'd1;
                  ch_d  = CH_SPACE;
                  op_d  = OpErase;
                end else begin
                  op_d = OpNop;
                end
                state_d = WRITE;
              end
              CH_FF: begin
                idx_d   = '0;
                state_d = CLEAR_ALL;
              end
              default: ;
            endcase
          end
        end
      end

      WRITE: begin
        VRAM_WE = (op_q != OpNop);
        state_d = IDLE;
        if (op_q == OpPut) begin
          if (col_q < LastCol) begin
            col_d = col_q + 7'd1;
          end else begin
            col_d   = '0;
            row_d   = row_next;
            idx_d   = '0;
            state_d = CLEAR_LINE;
          end
        end
      end

      CLEAR_LINE: begin
        VRAM_WE   = 1'b1;
        VRAM_ADDR = row_base + idx_q;
        VRAM_DATA = CH_SPACE;
        if (idx_q == LastLineI) begin
          idx_d   = '0;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        idx_d   = '0;
        state_d = CLEAR_ALL;
      end
    endcase

    if (Reset) begin
      DSR_Ready = 1'b0;
      VRAM_WE   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CLEAR_ALL;
      op_q    <= OpNop;
      ch_q    <= CH_SPACE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: doc/display_console_controller.md
# display_console_controller

Device-side consumer of the eLC-3 display registers. It takes characters written by the CPU to DDR and reports readiness through the DSR ready bit, so software polls DSR before each write. Each accepted character is rendered into a COLS×ROWS text buffer (character RAM read by the video scan-out). The block handles cursor advance, control characters, line wrap, row wrap and screen/line clearing.

## Interface
Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, text-buffer address width; COLS*ROWS ≤ 2^ADDR_W

Ports:
- Clk  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high
- DDR_Write  in  1  one-cycle strobe: the CPU wrote DDR this cycle
- Data_FromDDR  in  16  DDR contents; only [7:0] is used
- DSR_Ready  out  1  1 = able to accept a character; drives DSR[15]
- VRAM_WE  out  1  text-buffer write enable
- VRAM_ADDR  out  ADDR_W  cell address = Row*COLS + Col
- VRAM_DATA  out  8  character code written
- Cursor_Col  out  7  current column, 0..COLS-1
- Cursor_Row  out  5  current row, 0..ROWS-1

## Operation
States:
- CLEAR_ALL
  - Writes 0x20 to every cell, one per cycle, using the index counter 0..COLS*ROWS-1.
  - Then sets cursor to (0,0) and goes to IDLE.
- IDLE
  - DSR_Ready=1.
  - A DDR_Write is decoded using c = Data_FromDDR[7:0].
- WRITE
  - One cycle.
  - Writes c at the cursor, then advances the cursor.
- CLEAR_LINE
  - Writes 0x20 to cells (Cursor_Row, 0..COLS-1), one per cycle.
  - Then goes to IDLE.

Decode in IDLE:
- 0x20–0x7E: go to WRITE.
  - Advance: if Col < COLS-1, then Col+1 and return to IDLE.
  - Otherwise Col=0, Row=next row, and go to CLEAR_LINE.
- 0x0A (LF): Col=0, Row=next row, go to CLEAR_LINE.
- 0x0D (CR): Col=0, return to IDLE after one busy cycle.
- 0x08 (BS):
  - If Col>0: Col−1, then write 0x20 at the new position (via WRITE without advance).
  - If Col=0: no change; one busy cycle.
- 0x0C (FF): go to CLEAR_ALL, cursor ends at (0,0).
- Any other code: ignored, no busy cycle, DSR_Ready stays 1.

Row rules:
- Next row = Row+1, or 0 when Row = ROWS-1 (wrap, no scroll).
- The newly entered row is always cleared.

Other rules:
- DSR_Ready=0 in every state except IDLE.
- DDR_Write while DSR_Ready=0 is dropped silently, with no queuing.
- VRAM_WE=1 only in WRITE, CLEAR_ALL and CLEAR_LINE.
- Address arithmetic is unsigned, ADDR_W wide; Row*COLS uses a constant multiply.

## Timing
- Reset values: state CLEAR_ALL, index 0, Cursor (0,0), DSR_Ready 0, VRAM_WE 0 during the Reset cycle.
- Reset asserted in any state restarts CLEAR_ALL from index 0. A character in flight is lost.
- CLEAR_ALL: first VRAM write is in the cycle after Reset deasserts. DSR_Ready rises COLS*ROWS+1 cycles after deassert (2401 at defaults).
- Strobe accepted in cycle N:
  - Printable char: WRITE in N+1 (VRAM_WE=1, old cursor address). Cursor outputs update at the N+1→N+2 edge; DSR_Ready=1 in N+2.
  - CR, or BS at Col 0: DSR_Ready=0 in N+1 and 1 in N+2.
  - LF, or line wrap: CLEAR_LINE occupies COLS cycles; DSR_Ready returns COLS cycles after the last non-clear cycle.
- VRAM_* outputs are combinational from registered state/cursor/index. The text buffer samples them at the same Clk edge.

## Structure
- Shared package elc3_display_pkg:
  - state enum {CLEAR_ALL, IDLE, WRITE, CLEAR_LINE}
  - character constants CH_SPACE, CH_LF, CH_CR, CH_BS, CH_FF
  - printable range bounds
- Single module; no sub-module. The cursor and index counters live inline in the FSM's always_ff.

## Test plan
- Reset and clear: deassert Reset → 2400 writes of 0x20 to addrs 0..2399, then DSR_Ready=1 and cursor (0,0).
- Print: write 0x41 at (0,0) → VRAM_ADDR=0, VRAM_DATA=0x41 for one cycle; cursor becomes (1,0); DSR_Ready=1 two cycles after the strobe.
- Line wrap: 80 × 0x42 from (0,5) → last write at addr 479; then 80 clears at 480..559; cursor ends at (0,6).
- Row wrap: LF at row 29 → addrs 0..79 cleared, cursor (0,0). BS at col 0 → no write, cursor unchanged.
- Busy drop: strobe 0x43 during CLEAR_LINE → no write of 0x43, cursor unchanged after the clear.
- Mid-op reset: Reset during CLEAR_LINE → CLEAR_ALL restarts from addr 0, DSR_Ready=0 until 2401 cycles after deassert. FF → full clear, cursor (0,0).
